apb4_master_arbiter: RTL and testbench

- Multi-requester APB4 master that shares one APB4 bus among NREQ local requesters.
- Arbitrates round-robin, latches the winning request and sequences the APB IDLE -> SETUP -> ACCESS protocol. Wait states come from pready.
- Returns read data and error status to the winning requester. A watchdog aborts accesses to slaves that never respond.
- Sits upstream of the APB4 slave interfaces and register banks in the peripheral subsystem.

---
 rtl/apb4_pkg.sv | 13 +
 rtl/apb_rr_arbiter.sv | 32 +++
 rtl/apb4_master_arbiter.sv | 152 +++++++++++++++
 tb/tb_apb4_master_arbiter.sv | 337 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/apb4_pkg.sv
// Shared types and widths for the APB4 master arbiter and its sub-blocks.
package apb4_pkg;

    localparam int APB_DATA_W = 32;
    localparam int APB_STRB_W = 4;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_SETUP,
        ST_ACCESS
    } apb_state_e;

endpackage

// File: rtl/apb_rr_arbiter.sv
// Combinational round-robin picker: the first requester after last_grant wins.
// The scan wraps around.
module apb_rr_arbiter #(
    parameter  int N  = 2,
    localparam int IW = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]  req,
    input  logic          update,
    input  logic [IW-1:0] last_grant,
    output logic [N-1:0]  grant,
    output logic [IW-1:0] grant_idx
);

    always_comb begin : rr_scan
        logic          found;
        logic [IW-1:0] idx;
        found     = 1'b0;
        idx       = '0;
        grant     = '0;
        grant_idx = '0;
        // last_grant itself is scanned last, so it has the lowest priority.
        for (int k = 1; k <= N; k++) begin
            idx = IW'((int'(last_grant) + k) % N);
            if (update && !found && req[idx]) begin
                found      = 1'b1;
                grant[idx] = 1'b1;
                grant_idx  = idx;
            end
        end
    end

endmodule

// File: rtl/apb4_master_arbiter.sv
// Multi-requester APB4 master: round-robin arbitration, APB sequencing and a slave timeout.
//   state     | meaning
//   ST_IDLE   | bus idle, arbitrate among pending requests
//   ST_SETUP  | psel high, penable low, single cycle
//   ST_ACCESS | penable high, wait for pready or timeout
module apb4_master_arbiter
    import apb4_pkg::*;
#(
    parameter int ADDRWIDTH = 12,
    parameter int NREQ      = 2,
    parameter int TIMEOUT   = 16
) (
    input  logic                        pclk,
    input  logic                        presetn,
    input  logic [NREQ-1:0]             req_valid,
    output logic [NREQ-1:0]             req_ready,
    input  logic [NREQ-1:0]             req_write,
    input  logic [NREQ*ADDRWIDTH-1:0]   req_addr,
    input  logic [NREQ*APB_DATA_W-1:0]  req_wdata,
    input  logic [NREQ*APB_STRB_W-1:0]  req_strb,
    output logic [NREQ-1:0]             resp_valid,
    output logic [APB_DATA_W-1:0]       resp_rdata,
    output logic                        resp_err,
    output logic                        psel,
    output logic                        penable,
    output logic                        pwrite,
    output logic [ADDRWIDTH-1:0]        paddr,
    output logic [APB_DATA_W-1:0]       pwdata,
    output logic [APB_STRB_W-1:0]       pstrb,
    input  logic [APB_DATA_W-1:0]       prdata,
    input  logic                        pready,
    input  logic                        pslverr
);

    localparam int            IW       = (NREQ > 1) ? $clog2(NREQ) : 1;
    localparam int            CW       = $clog2(TIMEOUT);
    localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT - 1);

    apb_state_e              state_q, state_d;
    logic [IW-1:0]           last_q, last_d;
    logic [CW-1:0]           cnt_q, cnt_d;
    logic [NREQ-1:0]         owner_q, owner_d;
    logic [NREQ-1:0]         grant;
    logic [IW-1:0]           grant_idx;
    logic [NREQ-1:0]         req_ready_d, resp_valid_d;
    logic [APB_DATA_W-1:0]   resp_rdata_d, pwdata_d;
    logic                    resp_err_d, psel_d, penable_d, pwrite_d;
    logic [ADDRWIDTH-1:0]    paddr_d;
    logic [APB_STRB_W-1:0]   pstrb_d;

    apb_rr_arbiter #(.N(NREQ)) u_arb (
        .req        (req_valid),
        .update     (state_q == ST_IDLE),
        .last_grant (last_q),
        .grant      (grant),
        .grant_idx  (grant_idx)
    );

    always_comb begin
        state_d      = state_q;
        last_d       = last_q;
        cnt_d        = cnt_q;
        owner_d      = owner_q;
        req_ready_d  = '0;
        resp_valid_d = '0;
        resp_rdata_d = '0;
        resp_err_d   = 1'b0;
        psel_d       = psel;
        penable_d    = penable;
        pwrite_d     = pwrite;
        paddr_d      = paddr;
        pwdata_d     = pwdata;
        pstrb_d      = pstrb;
        case (state_q)
            ST_IDLE: begin
                if (|grant) begin
                    req_ready_d = grant;
                    owner_d     = grant;
                    last_d      = grant_idx;
                    pwrite_d    = req_write[grant_idx];
                    paddr_d     = req_addr[grant_idx*ADDRWIDTH +: ADDRWIDTH];
                    pwdata_d    = req_wdata[grant_idx*APB_DATA_W +: APB_DATA_W];
                    pstrb_d     = req_write[grant_idx] ?
                                  req_strb[grant_idx*APB_STRB_W +: APB_STRB_W] : '0;
                    psel_d      = 1'b1;
                    penable_d   = 1'b0;
                    state_d     = ST_SETUP;
                end
            end
            ST_SETUP: begin
                penable_d = 1'b1;
                cnt_d     = '0;
                state_d   = ST_ACCESS;
            end
            ST_ACCESS: begin
                // pready is checked first so a response on the last allowed cycle is not an abort.
                if (pready) begin
                    resp_valid_d = owner_q;
                    resp_rdata_d = pwrite ? '0 : prdata;
                    resp_err_d   = pslverr;
                    psel_d       = 1'b0;
                    penable_d    = 1'b0;
                    state_d      = ST_IDLE;
                end else if (cnt_q == CNT_LAST) begin
                    resp_valid_d = owner_q;
                    resp_err_d   = 1'b1;
                    psel_d       = 1'b0;
                    penable_d    = 1'b0;
                    state_d      = ST_IDLE;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge pclk or negedge presetn) begin
        if (!presetn) begin
            state_q    <= ST_IDLE;
            last_q     <= IW'(NREQ - 1);
            cnt_q      <= '0;
            owner_q    <= '0;
            req_ready  <= '0;
            resp_valid <= '0;
            resp_rdata <= '0;
            resp_err   <= 1'b0;
            psel       <= 1'b0;
            penable    <= 1'b0;
            pwrite     <= 1'b0;
            paddr      <= '0;
            pwdata     <= '0;
            pstrb      <= '0;
        end else begin
            state_q    <= state_d;
            last_q     <= last_d;
            cnt_q      <= cnt_d;
            owner_q    <= owner_d;
            req_ready  <= req_ready_d;
            resp_valid <= resp_valid_d;
            resp_rdata <= resp_rdata_d;
            resp_err   <= resp_err_d;
            psel       <= psel_d;
            penable    <= penable_d;
            pwrite     <= pwrite_d;
            paddr      <= paddr_d;
            pwdata     <= pwdata_d;
            pstrb      <= pstrb_d;
        end
    end

endmodule

// File: tb/tb_apb4_master_arbiter.sv
// Self-checking bench for apb4_master_arbiter with a response scoreboard.
module tb_apb4_master_arbiter;

    localparam int AW = 12;
    localparam int NR = 2;
    localparam int TO = 16;

    logic              pclk = 1'b0;
    logic              presetn;
    logic [NR-1:0]     req_valid, req_ready, req_write, resp_valid;
    logic [NR*AW-1:0]  req_addr;
    logic [NR*32-1:0]  req_wdata;
    logic [NR*4-1:0]   req_strb;
    logic [31:0]       resp_rdata, pwdata, prdata;
    logic              resp_err, psel, penable, pwrite, pready, pslverr;
    logic [AW-1:0]     paddr;
    logic [3:0]        pstrb;

    apb4_master_arbiter #(.ADDRWIDTH(AW), .NREQ(NR), .TIMEOUT(TO)) dut (
        .pclk(pclk), .presetn(presetn),
        .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
        .req_addr(req_addr), .req_wdata(req_wdata), .req_strb(req_strb),
        .resp_valid(resp_valid), .resp_rdata(resp_rdata), .resp_err(resp_err),
        .psel(psel), .penable(penable), .pwrite(pwrite), .paddr(paddr),
        .pwdata(pwdata), .pstrb(pstrb), .prdata(prdata), .pready(pready),
        .pslverr(pslverr)
    );

    always #5 pclk = ~pclk;

    typedef struct {
        int          req;
        logic [31:0] rdata;
        logic        err;
    } exp_t;

    exp_t sb[$];
    int   checks = 0;
    int   passed = 0;

    // Scoreboard: every response must match the oldest expectation pushed at stimulus time.
    always @(negedge pclk) begin
        exp_t e;
        if (presetn === 1'b1 && resp_valid !== '0) begin
            checks++;
            if (sb.size() == 0) begin
                $display("FAIL resp_unexpected got valid=%b with empty scoreboard", resp_valid);
            end else begin
                e = sb.pop_front();
                if ({resp_valid, resp_rdata, resp_err} !== {NR'(1 << e.req), e.rdata, e.err})
                    $display("FAIL resp_req%0d got valid=%b rdata=%h err=%b exp valid=%b rdata=%h err=%b",
                             e.req, resp_valid, resp_rdata, resp_err, NR'(1 << e.req), e.rdata, e.err);
                else
                    passed++;
            end
        end
    end

    task automatic wait_drain(input int budget, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < budget; i++) begin
            @(negedge pclk);
            #1;
            if (sb.size() == 0) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    task automatic run_wait(input int raise_at, output int acc, output bit done);
        acc  = 0;
        done = 1'b0;
        for (int i = 0; i < 60; i++) begin
            @(negedge pclk);
            if (resp_valid !== '0) begin
                done = 1'b1;
                break;
            end
            if (psel === 1'b1 && penable === 1'b1) begin
                acc++;
                if (acc == raise_at) pready = 1'b1;
            end
        end
    endtask

    task automatic test_reset();
        presetn = 1'b0; req_valid = '0; req_write = '0; req_addr = '0;
        req_wdata = '0; req_strb = '0; prdata = '0; pready = 1'b0; pslverr = 1'b0;
        #3;
        checks++;
        if ({req_ready, resp_valid, resp_rdata, resp_err, psel, penable, pwrite, paddr, pwdata, pstrb} !== '0)
            $display("FAIL reset_outputs got psel=%b paddr=%h req_ready=%b resp_valid=%b exp all zero",
                     psel, paddr, req_ready, resp_valid);
        else passed++;
        repeat (2) @(negedge pclk);
        presetn = 1'b1;
        repeat (2) @(negedge pclk);
        checks++;
        if ({psel, req_ready, resp_valid} !== '0)
            $display("FAIL reset_idle got psel=%b req_ready=%b resp_valid=%b exp 0", psel, req_ready, resp_valid);
        else passed++;
    endtask

    task automatic test_single_write();
        @(negedge pclk);
        req_write[0] = 1'b1; req_addr[11:0] = 12'h010; req_wdata[31:0] = 32'hDEADBEEF;
        req_strb[3:0] = 4'hF; pready = 1'b1; pslverr = 1'b0; prdata = 32'hA5A5A5A5;
        req_valid = 2'b01;
        sb.push_back('{0, 32'h0, 1'b0});
        @(negedge pclk);
        checks++;
        if ({req_ready, psel, penable, pwrite, paddr, pwdata, pstrb} !==
            {2'b01, 1'b1, 1'b0, 1'b1, 12'h010, 32'hDEADBEEF, 4'hF})
            $display("FAIL wr_setup got ready=%b psel=%b pen=%b pwrite=%b paddr=%h pwdata=%h pstrb=%h",
                     req_ready, psel, penable, pwrite, paddr, pwdata, pstrb);
        else passed++;
        req_valid = '0;
        @(negedge pclk);
        checks++;
        if ({psel, penable, resp_valid, req_ready} !== {1'b1, 1'b1, 2'b00, 2'b00})
            $display("FAIL wr_access got psel=%b pen=%b resp_valid=%b exp 1 1 00", psel, penable, resp_valid);
        else passed++;
        @(negedge pclk);
        checks++;
        if ({psel, penable, resp_valid} !== {1'b0, 1'b0, 2'b01})
            $display("FAIL wr_done got psel=%b pen=%b resp_valid=%b exp 0 0 01", psel, penable, resp_valid);
        else passed++;
        @(negedge pclk);
        checks++;
        if ({psel, resp_valid, req_ready} !== '0)
            $display("FAIL wr_after got psel=%b resp_valid=%b req_ready=%b exp 0", psel, resp_valid, req_ready);
        else passed++;
    endtask

    task automatic test_read_wait();
        req_write[1] = 1'b0; req_addr[23:12] = 12'h024; req_strb[7:4] = 4'hF;
        pready = 1'b0; prdata = 32'hFFFFFFFF;
        req_valid = 2'b10;
        sb.push_back('{1, 32'h12345678, 1'b0});
        @(negedge pclk);
        checks++;
        if ({req_ready, psel, penable, pwrite, paddr, pstrb} !== {2'b10, 1'b1, 1'b0, 1'b0, 12'h024, 4'h0})
            $display("FAIL rd_setup got ready=%b psel=%b pen=%b pwrite=%b paddr=%h pstrb=%h",
                     req_ready, psel, penable, pwrite, paddr, pstrb);
        else passed++;
        req_valid = '0;
        for (int i = 0; i < 3; i++) begin
            @(negedge pclk);
            checks++;
            if ({psel, penable, paddr, pstrb, resp_valid} !== {1'b1, 1'b1, 12'h024, 4'h0, 2'b00})
                $display("FAIL rd_access%0d got psel=%b pen=%b paddr=%h pstrb=%h resp_valid=%b",
                         i, psel, penable, paddr, pstrb, resp_valid);
            else passed++;
            if (i == 2) begin
                pready = 1'b1;
                prdata = 32'h12345678;
            end
        end
        @(negedge pclk);
        checks++;
        if ({psel, penable, resp_valid} !== {1'b0, 1'b0, 2'b10})
            $display("FAIL rd_done got psel=%b pen=%b resp_valid=%b exp 0 0 10", psel, penable, resp_valid);
        else passed++;
        prdata = 32'h5A5A5A5A;
    endtask

    task automatic test_fairness();
        int n;
        int last_cyc;
        bit ok;
        logic [NR-1:0] exp_ready;
        logic [AW-1:0] exp_addr;
        req_write = 2'b11; req_addr = {12'h200, 12'h100};
        req_wdata = {32'h22222222, 32'h11111111}; req_strb = {4'h3, 4'hF};
        pready = 1'b1; pslverr = 1'b0;
        for (int i = 0; i < 4; i++) sb.push_back('{i % 2, 32'h0, 1'b0});
        req_valid = 2'b11;
        n = 0;
        last_cyc = 0;
        for (int cyc = 0; cyc < 40 && n < 4; cyc++) begin
            @(negedge pclk);
            if (req_ready !== '0) begin
                exp_ready = (n % 2 == 0) ? 2'b01 : 2'b10;
                exp_addr  = (n % 2 == 0) ? 12'h100 : 12'h200;
                checks++;
                if ({req_ready, paddr} !== {exp_ready, exp_addr})
                    $display("FAIL fair_grant%0d got ready=%b paddr=%h exp ready=%b paddr=%h",
                             n, req_ready, paddr, exp_ready, exp_addr);
                else passed++;
                if (n > 0) begin
                    checks++;
                    if (cyc - last_cyc != 3)
                        $display("FAIL fair_gap%0d got %0d cycles exp 3", n, cyc - last_cyc);
                    else passed++;
                end
                last_cyc = cyc;
                n++;
                if (n == 4) req_valid = '0;
            end
            if (resp_valid !== '0) begin
                checks++;
                if (psel !== 1'b0) $display("FAIL fair_idle got psel=%b exp 0", psel);
                else passed++;
            end
        end
        req_valid = '0;
        checks++;
        if (n != 4) $display("FAIL fair_count got %0d grants exp 4", n);
        else passed++;
        wait_drain(20, ok);
        checks++;
        if (!ok) $display("FAIL fair_drain got %0d pending exp 0", sb.size());
        else passed++;
    endtask

    task automatic test_slverr();
        bit ok;
        req_write[0] = 1'b1; req_addr[11:0] = 12'h030; req_wdata[31:0] = 32'h0000ABCD;
        pready = 1'b1; pslverr = 1'b1; prdata = 32'hFFFF0000;
        req_valid = 2'b01;
        sb.push_back('{0, 32'h0, 1'b1});
        @(negedge pclk);
        checks++;
        if (req_ready !== 2'b01) $display("FAIL err_grant got %b exp 01", req_ready);
        else passed++;
        req_valid = '0;
        wait_drain(10, ok);
        checks++;
        if (!ok || {psel, penable} !== 2'b00)
            $display("FAIL err_done got ok=%b psel=%b pen=%b exp 1 0 0", ok, psel, penable);
        else passed++;
        pslverr = 1'b0;
    endtask

    task automatic test_timeout();
        int acc;
        bit done;
        // Slave never answers: abort after TO ACCESS cycles.
        req_write[1] = 1'b0; req_addr[23:12] = 12'h3FC; pready = 1'b0; prdata = 32'hBADC0DE5;
        @(negedge pclk);
        req_valid = 2'b10;
        sb.push_back('{1, 32'h0, 1'b1});
        @(negedge pclk);
        checks++;
        if (req_ready !== 2'b10) $display("FAIL to_grant got %b exp 10", req_ready);
        else passed++;
        req_valid = '0;
        run_wait(0, acc, done);
        checks++;
        if (!done || acc != TO || psel !== 1'b0)
            $display("FAIL to_abort got done=%b access_cycles=%0d psel=%b exp 1 %0d 0", done, acc, TO, psel);
        else passed++;
        // pready on the very last allowed cycle completes normally.
        req_write[0] = 1'b0; req_addr[11:0] = 12'h044; prdata = 32'h600DF00D; pslverr = 1'b0;
        @(negedge pclk);
        req_valid = 2'b01;
        sb.push_back('{0, 32'h600DF00D, 1'b0});
        @(negedge pclk);
        req_valid = '0;
        run_wait(TO, acc, done);
        checks++;
        if (!done || acc != TO || psel !== 1'b0)
            $display("FAIL to_edge got done=%b access_cycles=%0d psel=%b exp 1 %0d 0", done, acc, TO, psel);
        else passed++;
        // Next requester is served normally.
        req_write[1] = 1'b1; req_addr[23:12] = 12'h080; pready = 1'b1;
        @(negedge pclk);
        req_valid = 2'b10;
        sb.push_back('{1, 32'h0, 1'b0});
        @(negedge pclk);
        req_valid = '0;
        run_wait(0, acc, done);
        checks++;
        if (!done || acc != 1) $display("FAIL to_next got done=%b access_cycles=%0d exp 1 1", done, acc);
        else passed++;
    endtask

    task automatic test_reset_mid();
        bit ok;
        req_write[0] = 1'b1; req_addr[11:0] = 12'h0F0; pready = 1'b0;
        @(negedge pclk);
        req_valid = 2'b01;
        @(negedge pclk);
        req_valid = '0;
        repeat (3) @(negedge pclk);
        #2 presetn = 1'b0;
        #1;
        checks++;
        if ({req_ready, resp_valid, resp_rdata, resp_err, psel, penable, pwrite, paddr, pwdata, pstrb} !== '0)
            $display("FAIL rst_async got psel=%b pen=%b paddr=%h resp_valid=%b exp all zero",
                     psel, penable, paddr, resp_valid);
        else passed++;
        for (int i = 0; i < 3; i++) begin
            @(negedge pclk);
            checks++;
            if ({resp_valid, psel} !== '0) $display("FAIL rst_hold%0d got resp_valid=%b psel=%b exp 0", i, resp_valid, psel);
            else passed++;
        end
        presetn = 1'b1;
        req_write = 2'b11; pready = 1'b1;
        req_valid = 2'b11;
        sb.push_back('{0, 32'h0, 1'b0});
        @(negedge pclk);
        checks++;
        if (req_ready !== 2'b01) $display("FAIL rst_first_grant got %b exp 01", req_ready);
        else passed++;
        req_valid = '0;
        wait_drain(10, ok);
        checks++;
        if (!ok) $display("FAIL rst_drain got %0d pending exp 0", sb.size());
        else passed++;
    endtask

    initial begin
        test_reset();
        test_single_write();
        test_read_wait();
        test_fairness();
        test_slverr();
        test_timeout();
        test_reset_mid();
        repeat (3) @(negedge pclk);
        checks++;
        if (sb.size() != 0) $display("FAIL sb_empty got %0d pending exp 0", sb.size());
        else passed++;
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL global_timeout got no finish exp finish before 100000");
        $fatal(1);
    end

endmodule
